// File: rtl/hist_eq_lut_ctrl_pkg.sv
// Shared histogram constants and the LUT-build controller state set.
// Imported by the histogram, LUT-build and remap blocks.
package hist_eq_lut_ctrl_pkg;

  localparam int HIST_W          = 64;
  localparam int HIST_H          = 64;
  localparam int HIST_BINS       = 256;
  localparam int HIST_MAX_VAL    = 255;
  localparam int HIST_TOTAL      = HIST_W * HIST_H;
  localparam int HIST_TOTAL_BIT  = $clog2(HIST_TOTAL);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MIN_RD,
    S_MIN_CHK,
    S_CALC,
    S_RD,
    S_RD_WAIT,
    S_DIV_GO,
    S_DIV_WAIT,
    S_WRITE,
    S_FIN
  } state_e;

endpackage

// File: rtl/hist_eq_lut_ctrl_calc.sv
// Per-bin LUT arithmetic: numerator, bypass decision, quotient clamp.
// Purely combinational.
module hist_eq_lut_ctrl_calc
  import hist_eq_lut_ctrl_pkg::*;
#(
  parameter int CW      = HIST_TOTAL_BIT + 1,
  parameter int AW      = $clog2(HIST_BINS),
  parameter int LW      = $clog2(HIST_MAX_VAL + 1),
  parameter int MAX_VAL = HIST_MAX_VAL
) (
  input  logic [CW-1:0] cdf,
  input  logic [CW-1:0] cdf_min,
  input  logic [CW-1:0] den,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   quot,
  output logic          bypass,
  output logic [LW-1:0] lut_byp,
  output logic [31:0]   dividend,
  output logic [LW-1:0] lut_sat
);

  logic [CW-1:0] diff;

  always_comb begin
    diff     = cdf - cdf_min;
    dividend = 32'(diff) * 32'(MAX_VAL);
    bypass   = 1'b1;
    lut_byp  = '0;
    // den == 0 means one grey level: keep the identity map
    if (den == '0) begin
      lut_byp = LW'(idx);
    end else if (cdf > cdf_min) begin
      bypass = 1'b0;
    end
    if (quot > 32'(MAX_VAL)) begin
      lut_sat = LW'(MAX_VAL);
    end else begin
      lut_sat = LW'(quot);
    end
  end

endmodule

// File: rtl/hist_eq_lut_ctrl.sv
// Equalization LUT builder: CDF min scan, one divide per bin,
// LUT BRAM writes.
module hist_eq_lut_ctrl
  import hist_eq_lut_ctrl_pkg::*;
#(
  parameter int W               = HIST_W,
  parameter int H               = HIST_H,
  parameter int TOTAL_PIXEL     = W * H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W * H),
  parameter int BINS            = HIST_BINS,
  parameter int MAX_VAL         = HIST_MAX_VAL
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                cdf_rd_en,
  output logic [$clog2(BINS)-1:0]             cdf_addr,
  input  logic [TOTAL_PIXEL_BIT:0]            cdf_data,
  output logic                                div_start,
  output logic [31:0]                         div_dividend,
  output logic [TOTAL_PIXEL_BIT:0]            div_divisor,
  input  logic                                div_done,
  input  logic [31:0]                         div_quotient,
  output logic                                lut_we,
  output logic [$clog2(BINS)-1:0]             lut_addr,
  output logic [$clog2(MAX_VAL+1)-1:0]        lut_wdata
);

  localparam int AW = $clog2(BINS);
  localparam int CW = TOTAL_PIXEL_BIT + 1;
  localparam int LW = $clog2(MAX_VAL + 1);
  localparam logic [AW-1:0] LAST = AW'(BINS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] min_q, min_d;
  logic [CW-1:0] den_q, den_d;
  logic [31:0]   dvd_q, dvd_d;
  logic [LW-1:0] lut_q, lut_d;

  logic          c_bypass;
  logic [LW-1:0] c_lut_byp;
  logic [31:0]   c_dividend;
  logic [LW-1:0] c_lut_sat;

  hist_eq_lut_ctrl_calc #(
    .CW      (CW),
    .AW      (AW),
    .LW      (LW),
    .MAX_VAL (MAX_VAL)
  ) u_calc (
    .cdf      (cdf_data),
    .cdf_min  (min_q),
    .den      (den_q),
    .idx      (idx_q),
    .quot     (div_quotient),
    .bypass   (c_bypass),
    .lut_byp  (c_lut_byp),
    .dividend (c_dividend),
    .lut_sat  (c_lut_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      min_q   <= '0;
      den_q   <= '0;
      dvd_q   <= '0;
      lut_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      min_q   <= min_d;
      den_q   <= den_d;
      dvd_q   <= dvd_d;
      lut_q   <= lut_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    min_d        = min_q;
    den_d        = den_q;
    dvd_d        = dvd_q;
    lut_d        = lut_q;
    busy         = 1'b1;
    done         = 1'b0;
    cdf_rd_en    = 1'b0;
    cdf_addr     = '0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    lut_we       = 1'b0;
    lut_addr     = '0;
    lut_wdata    = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_d   = '0;
          state_d = S_MIN_RD;
        end
      end
      S_MIN_RD: begin
        cdf_rd_en = 1'b1;
        cdf_addr  = idx_q;
        state_d   = S_MIN_CHK;
      end
      S_MIN_CHK: begin
        if (cdf_data != '0) begin
          min_d   = cdf_data;
          state_d = S_CALC;
        end else if (idx_q == LAST) begin
          min_d   = '0;
          state_d = S_CALC;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_MIN_RD;
        end
      end
      S_CALC: begin
        den_d   = CW'(TOTAL_PIXEL) - min_q;
        idx_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        cdf_rd_en = 1'b1;
        cdf_addr  = idx_q;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        dvd_d = c_dividend;
        if (c_bypass) begin
          lut_d   = c_lut_byp;
          state_d = S_WRITE;
        end else begin
          state_d = S_DIV_GO;
        end
      end
      S_DIV_GO: begin
        div_start    = 1'b1;
        div_dividend = dvd_q;
        div_divisor  = den_q;
        state_d      = S_DIV_WAIT;
      end
      // operands held steady; a re-start would restart the divider
      S_DIV_WAIT: begin
        div_dividend = dvd_q;
        div_divisor  = den_q;
        if (div_done) begin
          lut_d   = c_lut_sat;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        lut_we    = 1'b1;
        lut_addr  = idx_q;
        lut_wdata = lut_q;
        if (idx_q == LAST) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hist_eq_lut_ctrl.sv
// Bench for hist_eq_lut_ctrl: small 4x4/8-bin instance plus a
// default 64x64/256-bin instance, with BRAM and divider models.
module tb_hist_eq_lut_ctrl;

  typedef int arr8_t[8];
  typedef struct {
    string nm;
    arr8_t cdf;
    arr8_t lut;
    int    ndiv;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- small instance (W=H=4, BINS=8, MAX_VAL=7)
  logic        s_start, s_busy, s_done, s_cdf_rd_en;
  logic [2:0]  s_cdf_addr;
  logic [4:0]  s_cdf_data;
  logic        s_div_start;
  logic [31:0] s_div_dividend;
  logic [4:0]  s_div_divisor;
  logic        s_div_done;
  logic [31:0] s_div_quot;
  logic        s_lut_we;
  logic [2:0]  s_lut_addr;
  logic [2:0]  s_lut_wdata;

  hist_eq_lut_ctrl #(
    .W(4), .H(4), .TOTAL_PIXEL(16), .TOTAL_PIXEL_BIT(4),
    .BINS(8), .MAX_VAL(7)
  ) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (s_start),
    .busy         (s_busy),
    .done         (s_done),
    .cdf_rd_en    (s_cdf_rd_en),
    .cdf_addr     (s_cdf_addr),
    .cdf_data     (s_cdf_data),
    .div_start    (s_div_start),
    .div_dividend (s_div_dividend),
    .div_divisor  (s_div_divisor),
    .div_done     (s_div_done),
    .div_quotient (s_div_quot),
    .lut_we       (s_lut_we),
    .lut_addr     (s_lut_addr),
    .lut_wdata    (s_lut_wdata)
  );

  int          s_mem[8];
  int          s_lut[8];
  int          s_lat = 33;
  logic        s_inj = 1'b0;
  int          s_nstart, s_ndone, s_nwr;
  int          s_hold_err, s_restart_err, s_proto_err;
  int          s_dcnt = 0;
  logic [31:0] s_dvd;
  logic [4:0]  s_dvs;
  logic        s_we_prev = 1'b0;
  logic [2:0]  s_wa_prev = '0;
  logic        s_done_prev = 1'b0;

  always @(posedge clk) begin
    if (s_cdf_rd_en) s_cdf_data <= 5'(s_mem[s_cdf_addr]);
    if (s_lut_we) begin
      s_lut[s_lut_addr] = int'(s_lut_wdata);
      s_nwr++;
    end
  end

  // divider model: fixed latency, checks operand hold and no restart
  always @(posedge clk) begin
    s_div_done <= 1'b0;
    if (!rst_n) begin
      s_dcnt = 0;
    end else if (s_div_start) begin
      if (s_dcnt != 0) s_restart_err++;
      s_dvd = s_div_dividend;
      s_dvs = s_div_divisor;
      s_dcnt = s_lat;
      s_nstart++;
    end else if (s_dcnt != 0) begin
      if (s_div_dividend != s_dvd || s_div_divisor != s_dvs)
        s_hold_err++;
      s_dcnt--;
      if (s_dcnt == 0) begin
        s_div_done <= 1'b1;
        s_div_quot <= (s_dvs == 0) ? 32'hFFFF_FFFF : s_dvd / 32'(s_dvs);
      end
    end
    if (s_inj) begin
      s_div_done <= 1'b1;
      s_div_quot <= 32'd5;
    end
  end

  always @(negedge clk) begin
    if (s_done) begin
      s_ndone++;
      if (s_busy || s_done_prev) s_proto_err++;
      if (!(s_we_prev && s_wa_prev == 3'd7)) s_proto_err++;
    end
    s_done_prev = s_done;
    s_we_prev   = s_lut_we;
    s_wa_prev   = s_lut_addr;
  end

  // ---------------- default instance (64x64, 256 bins)
  logic        b_start, b_busy, b_done, b_cdf_rd_en;
  logic [7:0]  b_cdf_addr;
  logic [12:0] b_cdf_data;
  logic        b_div_start;
  logic [31:0] b_div_dividend;
  logic [12:0] b_div_divisor;
  logic        b_div_done;
  logic [31:0] b_div_quot;
  logic        b_lut_we;
  logic [7:0]  b_lut_addr;
  logic [7:0]  b_lut_wdata;

  hist_eq_lut_ctrl dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (b_start),
    .busy         (b_busy),
    .done         (b_done),
    .cdf_rd_en    (b_cdf_rd_en),
    .cdf_addr     (b_cdf_addr),
    .cdf_data     (b_cdf_data),
    .div_start    (b_div_start),
    .div_dividend (b_div_dividend),
    .div_divisor  (b_div_divisor),
    .div_done     (b_div_done),
    .div_quotient (b_div_quot),
    .lut_we       (b_lut_we),
    .lut_addr     (b_lut_addr),
    .lut_wdata    (b_lut_wdata)
  );

  int          b_mem[256];
  int          b_lut[256];
  int          b_nstart, b_ndone, b_nwr, b_err;
  int          b_dcnt = 0;
  logic [31:0] b_dvd;
  logic [12:0] b_dvs;

  always @(posedge clk) begin
    if (b_cdf_rd_en) b_cdf_data <= 13'(b_mem[b_cdf_addr]);
    if (b_lut_we) begin
      b_lut[b_lut_addr] = int'(b_lut_wdata);
      b_nwr++;
    end
    b_div_done <= 1'b0;
    if (!rst_n) begin
      b_dcnt = 0;
    end else if (b_div_start) begin
      if (b_dcnt != 0) b_err++;
      b_dvd = b_div_dividend;
      b_dvs = b_div_divisor;
      b_dcnt = 33;
      b_nstart++;
    end else if (b_dcnt != 0) begin
      if (b_div_dividend != b_dvd || b_div_divisor != b_dvs) b_err++;
      b_dcnt--;
      if (b_dcnt == 0) begin
        b_div_done <= 1'b1;
        b_div_quot <= (b_dvs == 0) ? 32'hFFFF_FFFF : b_dvd / 32'(b_dvs);
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) begin
      b_ndone++;
      if (b_busy) b_err++;
    end
  end

  // ---------------- reference model (small config)
  function automatic void ref_lut(input arr8_t cdf, output arr8_t lut,
                                  output int ndiv);
    int mn, den, q;
    bit found;
    mn = 0;
    found = 0;
    ndiv = 0;
    for (int i = 0; i < 8; i++)
      if (!found && cdf[i] != 0) begin
        mn = cdf[i];
        found = 1;
      end
    den = 16 - mn;
    for (int i = 0; i < 8; i++) begin
      if (den == 0) lut[i] = i % 8;
      else if (cdf[i] <= mn) lut[i] = 0;
      else begin
        ndiv++;
        q = (cdf[i] - mn) * 7 / den;
        lut[i] = (q > 7) ? 7 : q;
      end
    end
  endfunction

  task automatic run_s(input string nm, input arr8_t exp, input int ndiv,
                       input int mode);
    int cyc;
    bit pulsed;
    s_nstart = 0; s_ndone = 0; s_nwr = 0;
    s_hold_err = 0; s_restart_err = 0; s_proto_err = 0;
    for (int i = 0; i < 8; i++) s_lut[i] = -1;
    pulsed = 0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk({nm, " busy_after_start"}, longint'(s_busy), 1);
    cyc = 0;
    while (s_ndone == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      s_start = 1'b0;
      s_inj = 1'b0;
      if (mode == 1 && !pulsed && s_nstart > 0) begin
        s_start = 1'b1;
        pulsed = 1;
      end
      if (mode == 3) s_inj = 1'($urandom_range(0, 1));
    end
    s_start = 1'b0;
    s_inj = 1'b0;
    chk({nm, " timeout"}, longint'(cyc < 4000), 1);
    if (mode == 1) chk({nm, " restart_pulsed"}, longint'(pulsed), 1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s lut%0d", nm, i), s_lut[i], exp[i]);
    chk({nm, " div_starts"}, s_nstart, ndiv);
    chk({nm, " dones"}, s_ndone, 1);
    chk({nm, " writes"}, s_nwr, 8);
    chk({nm, " div_hold"}, s_hold_err, 0);
    chk({nm, " div_restart"}, s_restart_err, 0);
    chk({nm, " done_protocol"}, s_proto_err, 0);
  endtask

  vec_t tbl[5];

  initial begin
    int    cyc;
    arr8_t rc, rl;
    int    rn;
    logic [63:0] outs;

    tbl[0] = '{"cdf_min4",  '{0,0,4,4,8,12,16,16},
               '{0,0,0,0,2,4,7,7}, 4};
    tbl[1] = '{"single_val", '{0,0,0,16,16,16,16,16},
               '{0,1,2,3,4,5,6,7}, 0};
    tbl[2] = '{"all_zero",  '{0,0,0,0,0,0,0,0},
               '{0,0,0,0,0,0,0,0}, 0};
    tbl[3] = '{"saturate",  '{0,2,31,31,20,16,16,16},
               '{0,0,7,7,7,7,7,7}, 6};
    tbl[4] = '{"mixed",     '{0,3,5,9,10,16,16,16},
               '{0,0,1,3,3,7,7,7}, 6};

    rst_n = 1'b0;
    s_start = 1'b0;
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) s_mem[i] = 0;
    for (int i = 0; i < 256; i++) b_mem[i] = 0;
    repeat (3) @(negedge clk);
    outs = {13'd0, s_busy, s_done, s_cdf_rd_en, s_cdf_addr, s_div_start,
            s_div_dividend, s_div_divisor, s_lut_we, s_lut_addr,
            s_lut_wdata};
    chk("reset small outputs", longint'(outs), 0);
    outs = {b_busy, b_done, b_cdf_rd_en, b_div_start, b_lut_we,
            b_cdf_addr, b_div_divisor, b_lut_addr, b_lut_wdata, 19'd0};
    chk("reset big ctl outputs", longint'(outs), 0);
    chk("reset big dividend", longint'(b_div_dividend), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      s_mem = tbl[k].cdf;
      s_lat = 33;
      run_s(tbl[k].nm, tbl[k].lut, tbl[k].ndiv, 0);
    end

    // second start while a divide is outstanding
    s_mem = tbl[0].cdf;
    run_s("start_in_div_wait", tbl[0].lut, tbl[0].ndiv, 1);

    // stray div_done with no divide outstanding
    s_mem = tbl[2].cdf;
    run_s("stray_div_done", tbl[2].lut, 0, 3);

    // reset during DIV_WAIT
    s_mem = tbl[0].cdf;
    s_nstart = 0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 0;
    while (s_nstart == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid reach_div", longint'(cyc < 200), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    outs = {13'd0, s_busy, s_done, s_cdf_rd_en, s_cdf_addr, s_div_start,
            s_div_dividend, s_div_divisor, s_lut_we, s_lut_addr,
            s_lut_wdata};
    chk("rst_mid outputs", longint'(outs), 0);
    rst_n = 1'b1;
    run_s("rst_mid rerun", tbl[0].lut, tbl[0].ndiv, 0);

    // randomized CDFs against the reference model
    for (int t = 0; t < 20; t++) begin
      bit first;
      first = 1;
      for (int i = 0; i < 8; i++) begin
        rc[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
        if (first && rc[i] != 0) begin
          if (rc[i] > 16) rc[i] = int'($urandom_range(1, 16));
          first = 0;
        end
      end
      ref_lut(rc, rl, rn);
      s_mem = rc;
      s_lat = int'($urandom_range(1, 40));
      run_s($sformatf("rand%0d", t), rl, rn, 0);
    end

    // default configuration, uniform 16 per bin
    for (int i = 0; i < 256; i++) begin
      b_mem[i] = 16 * (i + 1);
      b_lut[i] = -1;
    end
    b_nstart = 0; b_ndone = 0; b_nwr = 0; b_err = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("big busy_after_start", longint'(b_busy), 1);
    cyc = 0;
    while (b_ndone == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("big timeout", longint'(cyc < 20000), 1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 256; i++)
      chk($sformatf("big lut%0d", i), b_lut[i], (16 * i * 255) / 4080);
    chk("big lut255", b_lut[255], 255);
    chk("big div_starts", b_nstart, 255);
    chk("big dones", b_ndone, 1);
    chk("big writes", b_nwr, 256);
    chk("big protocol", b_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
